// File: rtl/bcd8421_decoder.sv
// Sequential 8421 BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional input digit range check enabled by defining BCD_DEC_ERRCHK_EN.
module bcd8421_decoder #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      bin,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e                state_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [BIN_W-1:0]      bin_q;
    logic [CntW-1:0]       cnt_q;
    logic                  err_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [4*DIGITS-1:0]   shift_bcd;
    logic [4*DIGITS-1:0]   corr_bcd;
    logic [BIN_W-1:0]      shift_bin;
    logic                  bad_digit;

    // One step: shift {bcd, bin} right, then undo the doubling carry-in on digits >= 8.
    always_comb begin
        shift_bin = {bcd_q[0], bin_q[BIN_W-1:1]};
        shift_bcd = {1'b0, bcd_q[4*DIGITS-1:1]};
        corr_bcd  = shift_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (shift_bcd[4*i +: 4] >= 4'd8) begin
                corr_bcd[4*i +: 4] = shift_bcd[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_DEC_ERRCHK_EN
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        bin_q      <= '0;
                        if (bad_digit) begin
                            bcd_q       <= '0;
                            cnt_q       <= '0;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            bcd_q   <= bcd;
                            cnt_q   <= CntW'(BIN_W - 1);
                            state_q <= StConv;
                        end
                    end
                end
                StConv: begin
                    bcd_q <= corr_bcd;
                    bin_q <= shift_bin;
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        err_q       <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    err_q       <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin       = bin_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd8421_decoder.sv
// Directed bench for bcd8421_decoder (DIGITS=2, BIN_W=7); error path checked when
// BCD_DEC_ERRCHK_EN is defined, otherwise the plain-latency behaviour.
module tb_bcd8421_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] bcd;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] bin;
    logic       err;
    logic       out_valid;
    logic       out_ready;

    int total;
    int passed;

    bcd8421_decoder #(
        .DIGITS (2),
        .BIN_W  (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd       (bcd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Called #1 after an edge with the DUT idle; accepts at the next edge, then waits for out_valid.
    task automatic convert(input string tag, input logic [7:0] val, input int exp_lat,
                           input logic [6:0] exp_bin, input logic exp_err, input bit chk_bin);
        int lat;
        lat = 99;
        bcd      = val;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (chk_bin) check({tag, "_bin"}, bin, exp_bin);
        check({tag, "_err"}, err, exp_err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_after_hs"}, out_valid, 0);
        check({tag, "_rdy_after_hs"}, in_ready, 1);
    endtask

    initial begin
        int t1, t2, seen;
        logic [6:0] b1, b2;
        total     = 0;
        passed    = 0;
        clk       = 1'b0;
        rst_n     = 1'b1;
        bcd       = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_bin", bin, 0);
        check("reset_err", err, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        convert("bcd99", 8'h99, 7, 7'd99, 1'b0, 1'b1);
        convert("bcd00", 8'h00, 7, 7'd0, 1'b0, 1'b1);
        convert("bcd42", 8'h42, 7, 7'd42, 1'b0, 1'b1);
        convert("bcd10", 8'h10, 7, 7'd10, 1'b0, 1'b1);
`ifdef BCD_DEC_ERRCHK_EN
        convert("bcd3A", 8'h3A, 1, 7'd0, 1'b1, 1'b1);
        check("bcd3A_err_cleared", err, 0);
`else
        convert("bcd3A", 8'h3A, 7, 7'd0, 1'b0, 1'b0);
`endif

        // Stall in DONE with a competing operand offered
        convert("bcd27", 8'h27, 7, 7'd27, 1'b0, 1'b1);
        bcd      = 8'h63;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
        end
        check("stall_pre_valid", out_valid, 1);
        bcd      = 8'h11;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_bin", bin, 63);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall_rdy_after_hs", in_ready, 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        check("stall_ignored_input", out_valid, 0);

        // Asynchronous reset in the third CONV cycle
        bcd      = 8'h99;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_bin", bin, 0);
        check("midreset_err", err, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        convert("bcd57", 8'h57, 7, 7'd57, 1'b0, 1'b1);

        // Back-to-back with in_valid and out_ready held high
        t1 = 0; t2 = 0; seen = 0; b1 = '0; b2 = '0;
        bcd       = 8'h01;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) bcd = 8'h98;
            if (out_valid) begin
                if (seen == 0) begin
                    t1 = c;
                    b1 = bin;
                end else begin
                    t2 = c;
                    b2 = bin;
                    in_valid = 1'b0;
                end
                seen++;
            end
            if (seen == 2) break;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_count", seen, 2);
        check("b2b_first_bin", b1, 1);
        check("b2b_second_bin", b2, 98);
        check("b2b_first_lat", t1, 7);
        check("b2b_spacing", t2 - t1, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
